// File: rtl/axi_line_fetch_pkg.sv
// Shared AXI read-channel constants and the line-fetch FSM state type.
package axi_line_fetch_pkg;

    localparam int unsigned AXI_ID_W    = 4;
    localparam int unsigned AXI_ADDR_W  = 32;
    localparam int unsigned AXI_DATA_W  = 32;
    localparam int unsigned AXI_LEN_W   = 4;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] BURST_INCR = 2'b01;
    localparam logic [AXI_RESP_W-1:0]  RESP_OKAY  = 2'b00;
    localparam logic [AXI_SIZE_W-1:0]  SIZE_4B    = 3'b010;

    // Clears the byte offset within a 16-byte line.
    localparam logic [AXI_ADDR_W-1:0] LINE_MASK = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR,
        StDone
    } fetch_state_e;

endpackage

// File: rtl/axi_line_fetch.sv
// Cache line-fill engine: turns one miss request into a 4-beat INCR AXI read burst
// and hands the assembled 128-bit line back to the cache.
module axi_line_fetch
    import axi_line_fetch_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] MASTER_ID  = 4'h1,
    parameter int unsigned         LINE_WORDS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [AXI_ADDR_W-1:0]               req_addr,
    input  logic                                flush,
    output logic                                line_valid,
    input  logic                                line_ready,
    output logic [AXI_ADDR_W-1:0]               line_addr,
    output logic [LINE_WORDS*AXI_DATA_W-1:0]    line_data,
    output logic                                line_err,
    output logic [AXI_ID_W-1:0]                 arid,
    output logic [AXI_ADDR_W-1:0]               araddr,
    output logic [AXI_LEN_W-1:0]                arlen,
    output logic [AXI_SIZE_W-1:0]               arsize,
    output logic [AXI_BURST_W-1:0]              arburst,
    output logic                                arvalid,
    input  logic                                arready,
    input  logic [AXI_ID_W-1:0]                 rid,
    input  logic [AXI_DATA_W-1:0]               rdata,
    input  logic [AXI_RESP_W-1:0]               rresp,
    input  logic                                rlast,
    input  logic                                rvalid,
    output logic                                rready
);

    fetch_state_e state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         drop_q, drop_d;
    // Set once every word has been written; later beats are overrun and discarded.
    logic         full_q, full_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_WORDS-1:0][AXI_DATA_W-1:0] words_q, words_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            full_q  <= 1'b0;
            addr_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            full_q  <= full_d;
            addr_q  <= addr_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        drop_d  = drop_q;
        full_d  = full_q;
        addr_d  = addr_q;
        words_d = words_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr & LINE_MASK;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    drop_d  = 1'b0;
                    full_d  = 1'b0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (flush) drop_d = 1'b1;
                if (arready) state_d = StR;
            end
            StR: begin
                if (flush) drop_d = 1'b1;
                if (rvalid) begin
                    if (full_q) begin
                        err_d = 1'b1;
                    end else begin
                        words_d[cnt_q] = rdata;
                        cnt_d          = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) full_d = 1'b1;
                    end
                    if (rresp != RESP_OKAY || rid != MASTER_ID) err_d = 1'b1;
                    if (rlast) begin
                        if (!full_q && cnt_q != 2'd3) err_d = 1'b1;
                        state_d = (drop_q || flush) ? StIdle : StDone;
                    end
                end
            end
            StDone: begin
                if (line_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs come from state only, never from the partner's ready/valid.
    assign req_ready  = (state_q == StIdle);
    assign arvalid    = (state_q == StAr);
    assign rready     = (state_q == StR);
    assign line_valid = (state_q == StDone);
    assign line_err   = (state_q == StDone) && err_q;

    assign line_addr  = addr_q;
    assign line_data  = words_q;

    assign arid       = MASTER_ID;
    assign araddr     = addr_q;
    assign arlen      = AXI_LEN_W'(LINE_WORDS - 1);
    assign arsize     = SIZE_4B;
    assign arburst    = BURST_INCR;

endmodule

// File: tb/tb_axi_line_fetch.sv
// Directed bench for axi_line_fetch: drives the cache and AXI slave sides by hand
// and compares outputs on the falling edge against hand-computed values.
module tb_axi_line_fetch;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic         flush = 1'b0;
    logic         line_valid;
    logic         line_ready = 1'b0;
    logic [31:0]  line_addr;
    logic [127:0] line_data;
    logic         line_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [3:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [3:0]   rid = '0;
    logic [31:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_addr;

    always #5 clk = ~clk;

    axi_line_fetch #(
        .MASTER_ID (4'h1),
        .LINE_WORDS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .line_valid(line_valid),
        .line_ready(line_ready),
        .line_addr (line_addr),
        .line_data (line_data),
        .line_err  (line_err),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, " req_ready"}, req_ready, 1'b1);
        check({tag, " arvalid"}, arvalid, 1'b0);
        check({tag, " rready"}, rready, 1'b0);
        check({tag, " line_valid"}, line_valid, 1'b0);
        check({tag, " line_err"}, line_err, 1'b0);
    endtask

    task automatic start_req(input logic [31:0] addr, input logic [31:0] line);
        exp_addr  = line;
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        check("ar latency arvalid", arvalid, 1'b1);
        check("ar req_ready low", req_ready, 1'b0);
        check("araddr", araddr, exp_addr);
        check("arlen", arlen, 4'h3);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);
        check("arid", arid, 4'h1);
    endtask

    task automatic ar_accept(input int stall);
        for (int i = 0; i < stall; i++) begin
            check("stall arvalid", arvalid, 1'b1);
            check("stall araddr", araddr, exp_addr);
            check("stall rready", rready, 1'b0);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("post ar arvalid", arvalid, 1'b0);
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id,
                        input logic last);
        check("beat rready", rready, 1'b1);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rid    = id;
        rlast  = last;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic finish_line(input logic [127:0] exp_data, input logic [127:0] mask,
                               input logic exp_err, input int hold);
        for (int i = 0; i <= hold; i++) begin
            check("line_valid", line_valid, 1'b1);
            check("line_data", line_data & mask, exp_data & mask);
            check("line_err", line_err, exp_err);
            check("line_addr", line_addr, exp_addr);
            if (i < hold) tick();
        end
        line_ready = 1'b1;
        check("done req_ready", req_ready, 1'b0);
        tick();
        line_ready = 1'b0;
        check("after line valid", line_valid, 1'b0);
        check("after line req_ready", req_ready, 1'b1);
    endtask

    localparam logic [127:0] ALL   = {128{1'b1}};
    localparam logic [127:0] LOW64 = {{64{1'b0}}, {64{1'b1}}};

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        idle_outputs("reset");
        check("reset line_data", line_data, 128'h0);
        check("reset line_addr", line_addr, 32'h0);

        // Basic fill, flush in IDLE ignored
        flush = 1'b1;
        start_req(32'h0000_1238, 32'h0000_1230);
        flush = 1'b0;
        ar_accept(0);
        beat(32'hA0, 2'b00, 4'h1, 1'b0);
        beat(32'hA1, 2'b00, 4'h1, 1'b0);
        beat(32'hA2, 2'b00, 4'h1, 1'b0);
        beat(32'hA3, 2'b00, 4'h1, 1'b1);
        finish_line(128'h000000A3_000000A2_000000A1_000000A0, ALL, 1'b0, 0);

        // AR stall 5 cycles, line_ready low 3 cycles with flush in DONE
        start_req(32'h0000_444C, 32'h0000_4440);
        ar_accept(5);
        beat(32'hB0, 2'b00, 4'h1, 1'b0);
        beat(32'hB1, 2'b00, 4'h1, 1'b0);
        beat(32'hB2, 2'b00, 4'h1, 1'b0);
        beat(32'hB3, 2'b00, 4'h1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        finish_line(128'h000000B3_000000B2_000000B1_000000B0, ALL, 1'b0, 2);

        // SLVERR on beat 2
        start_req(32'h8000_0004, 32'h8000_0000);
        ar_accept(1);
        beat(32'hC0, 2'b00, 4'h1, 1'b0);
        beat(32'hC1, 2'b10, 4'h1, 1'b0);
        beat(32'hC2, 2'b00, 4'h1, 1'b0);
        beat(32'hC3, 2'b00, 4'h1, 1'b1);
        finish_line(128'h000000C3_000000C2_000000C1_000000C0, ALL, 1'b1, 0);

        // Early rlast on beat 2
        start_req(32'h0000_0020, 32'h0000_0020);
        ar_accept(0);
        beat(32'hD0, 2'b00, 4'h1, 1'b0);
        beat(32'hD1, 2'b00, 4'h1, 1'b1);
        finish_line(128'h000000D1_000000D0, LOW64, 1'b1, 0);

        // Wrong rid on beat 3
        start_req(32'h0000_0100, 32'h0000_0100);
        ar_accept(0);
        beat(32'h50, 2'b00, 4'h1, 1'b0);
        beat(32'h51, 2'b00, 4'h1, 1'b0);
        beat(32'h52, 2'b00, 4'h5, 1'b0);
        beat(32'h53, 2'b00, 4'h1, 1'b1);
        finish_line(128'h00000053_00000052_00000051_00000050, ALL, 1'b1, 0);

        // Fifth beat overruns: discarded, error flagged
        start_req(32'h0000_0200, 32'h0000_0200);
        ar_accept(0);
        beat(32'hE0, 2'b00, 4'h1, 1'b0);
        beat(32'hE1, 2'b00, 4'h1, 1'b0);
        beat(32'hE2, 2'b00, 4'h1, 1'b0);
        beat(32'hE3, 2'b00, 4'h1, 1'b0);
        beat(32'hE4, 2'b00, 4'h1, 1'b1);
        finish_line(128'h000000E3_000000E2_000000E1_000000E0, ALL, 1'b1, 0);

        // Flush after beat 1: drain, no line delivered
        start_req(32'h0000_0300, 32'h0000_0300);
        ar_accept(0);
        beat(32'hF0, 2'b00, 4'h1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush line_valid", line_valid, 1'b0);
        beat(32'hF1, 2'b00, 4'h1, 1'b0);
        beat(32'hF2, 2'b00, 4'h1, 1'b0);
        beat(32'hF3, 2'b00, 4'h1, 1'b1);
        idle_outputs("flush end");
        tick();
        check("flush later line_valid", line_valid, 1'b0);

        // Reset mid-burst
        start_req(32'h0000_0400, 32'h0000_0400);
        ar_accept(0);
        beat(32'h70, 2'b00, 4'h1, 1'b0);
        rst = 1'b1;
        tick();
        check("midrst arvalid", arvalid, 1'b0);
        check("midrst rready", rready, 1'b0);
        check("midrst line_valid", line_valid, 1'b0);
        check("midrst line_data", line_data, 128'h0);
        rst = 1'b0;
        tick();
        idle_outputs("post reset");
        check("post reset line_addr", line_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_line_fetch.md
AXI_LINE_FETCH -- requirements
Module: axi_line_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter MASTER_ID, default 4'h1: AXI ID driven on arid and expected on rid.
REQ-003 Parameter LINE_WORDS, default 4: beats per burst; only the value 4 is supported.
REQ-004 Ports SHALL be, as name / direction / width / meaning:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 req_valid  in  1  line-fill request from cache
 req_ready  out  1  block can accept a request
 req_addr  in  32  byte address of the miss
 flush  in  1  discard the in-flight request's result
 line_valid  out  1  filled line available
 line_ready  in  1  cache consumes line
 line_addr  out  32  16-byte-aligned line address
 line_data  out  128  word i at bits [32i+31:32i]
 line_err  out  1  fill completed with an error
 arid  out  4  read ID
 araddr  out  32  burst start address
 arlen  out  4  burst length - 1
 arsize  out  3  beat size code
 arburst  out  2  burst type
 arvalid  out  1  address valid
 arready  in  1  slave accepts address
 rid  in  4  response ID
 rdata  in  32  read data
 rresp  in  2  response code
 rlast  in  1  last beat
 rvalid  in  1  data valid
 rready  out  1  master accepts data

Function
REQ-005 The FSM SHALL have four states: IDLE, AR, R, DONE.
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready, and the FSM goes IDLE->AR.
REQ-007 On acceptance the block SHALL latch line_addr = {req_addr[31:4], 4'h0}, clear the beat counter and clear the error flag.
REQ-008 In AR: arvalid=1; araddr=line_addr; arlen=4'h3; arsize=3'b010; arburst=INCR (2'b01); arid=MASTER_ID.
REQ-009 AR fields SHALL stay stable until arready; AR->R occurs on arvalid & arready.
REQ-010 arvalid SHALL be asserted first in the cycle after acceptance, i.e. request-to-AR latency is 1 cycle.
REQ-011 In R: rready=1. On each rvalid & rready, rdata SHALL be written to word[cnt], and the 2-bit cnt SHALL increment.
REQ-012 The error flag SHALL be set, sticky, on any handshaken beat with rresp != 2'b00 or rid != MASTER_ID.
REQ-013 rlast on a beat with cnt != 3 SHALL set the error flag and end the burst.
REQ-014 Beats after the fourth without rlast SHALL be accepted and their data discarded (no word overwrite); the error flag SHALL be set; the burst ends at rlast.
REQ-015 On the rlast handshake, R->DONE; line_data is complete in DONE.
REQ-016 In DONE: line_valid=1 and line_err=error flag. line_data, line_addr and line_err SHALL be held until line_ready.
REQ-017 DONE & line_ready SHALL move the FSM to IDLE; req_ready SHALL stay 0 in that cycle.
REQ-018 flush in AR or R SHALL set a drop flag. The AXI transaction still completes (arvalid held to handshake, all beats drained to rlast), then the FSM goes R->IDLE without asserting line_valid.
REQ-019 flush in IDLE or DONE SHALL have no effect.
REQ-020 arvalid, rready and line_valid SHALL never depend combinationally on arready, rvalid or line_ready.

Reset
REQ-021 While rst=1 at a clk edge, the block SHALL set: FSM=IDLE; cnt=0; error and drop flags=0; line_data=0; line_addr=0.
REQ-022 Outputs SHALL read: arvalid=0, rready=0, line_valid=0, line_err=0 and req_ready=1 in the first cycle after reset deasserts.
REQ-023 Reset mid-burst SHALL return the block to IDLE immediately; no obligation to drain the outstanding burst is placed on the block.

Structure
REQ-024 AXI width constants (ID 4, ADDR 32, DATA 32, LEN 4, SIZE 3, BURST 2), BURST_INCR, RESP_OKAY and the FSM state enum SHALL live in the shared AXI package.
REQ-025 The block SHALL be a single module; no sub-module is required.

Verification
REQ-026 req_addr=0x0000_1238, arready at once, 4 OKAY beats 0xA0..0xA3 with rlast on the 4th -> araddr=0x1230, arlen=3, line_data=0x000000A3_000000A2_000000A1_000000A0, line_err=0.
REQ-027 arready held low 5 cycles -> arvalid and araddr stable all 5 cycles, no rready before the AR handshake.
REQ-028 Beat 2 with rresp=2'b10 -> all 4 words stored, line_err=1 in DONE.
REQ-029 rlast on beat 2 -> DONE after 2 beats, line_err=1.
REQ-030 flush pulsed in R after beat 1 -> remaining beats drained, return to IDLE, line_valid never asserted, req_ready=1 the next cycle.
REQ-031 line_ready held low 3 cycles in DONE, then rst asserted during a later burst -> outputs held until line_ready; on reset, FSM to IDLE and arvalid=rready=line_valid=0.
